// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-RAM responder: access widths and FSM states.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } ram_size_e;

  localparam logic [1:0] RAM_SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables/replication and load extraction/extension.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (size_i)
      BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7] & ~is_unsigned_i}}, byte_sel};
      end
      HALF_WORD: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15] & ~is_unsigned_i}}, half_sel};
      end
      WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-RAM responder: one request in flight, LATENCY wait states, registered response.
// Optional store protection of words [0, RO_WORDS) when DMEM_WRITE_PROTECT_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned RO_WORDS    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Aw      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
`ifdef DMEM_WRITE_PROTECT_EN
  localparam bit WpEn = 1'b1;
`else
  localparam bit WpEn = 1'b0;
`endif

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [Aw-1:0] word_idx;
  logic [31:0] word_rd, wdata_sh, rdata_ext;
  logic [3:0]  be;
  logic        access_now, wp_err, acc_err, mem_we;

  assign word_idx   = addr_q[Aw+1:2];
  assign word_rd    = mem[word_idx];
  assign access_now = (state_q == DMEM_WAIT) && (cnt_q == 4'd0);
  assign wp_err     = WpEn && we_q && ({{(32-Aw){1'b0}}, word_idx} < RO_WORDS);
  assign acc_err    = (size_q == RAM_SIZE_RSVD)
                   || ((size_q == HALF_WORD) && addr_q[0])
                   || ((size_q == WORD) && (addr_q[1:0] != 2'b00))
                   || (addr_q[31:Aw+2] != '0)
                   || wp_err;
  assign mem_we     = access_now && we_q && !acc_err;

  dmem_lane_align u_lane_align (
    .size_i        (size_q),
    .addr_lo_i     (addr_q[1:0]),
    .is_unsigned_i (uns_q),
    .wdata_i       (wdata_q),
    .rdata_i       (word_rd),
    .be_o          (be),
    .wdata_o       (wdata_sh),
    .rdata_o       (rdata_ext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = CntInit;
          state_d = DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = DMEM_RESP;
          resp_valid_d = 1'b1;
          err_d        = acc_err;
          rdata_d      = (we_q || acc_err) ? 32'h0 : rdata_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMEM_RESP: begin
        if (resp_ready) begin
          state_d      = DMEM_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
    // Ready is registered, so a completing response blocks acceptance for that cycle.
    req_ready_d = (state_d == DMEM_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
